// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and the command sequencer state encoding.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StWrResp,
        StRd,
        StRdData,
        StDone
    } state_e;

endpackage

// File: rtl/axi_lite_arb_master_if.sv
// AXI4-Lite bus bundle between the arbitrating master and a single slave port.
interface axi_lite_arb_master_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
);

    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; on a tie the requester not granted last time wins.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    logic last_grant_q;

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_q <= 1'b1;
        end else if (advance_i && (gnt_o != 2'b00)) begin
            last_grant_q <= gnt_o[1];
        end
    end

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_grant_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/axi_lite_arb_master.sv
// Shares one AXI4-Lite slave port between two req/done clients, one command at a time.
module axi_lite_arb_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETN,

    input  logic                    r0_req,
    input  logic                    r0_we,
    input  logic [ADDR_WIDTH-1:0]   r0_addr,
    input  logic [DATA_WIDTH-1:0]   r0_wdata,
    input  logic [DATA_WIDTH/8-1:0] r0_wstrb,
    output logic                    r0_done,
    output logic [DATA_WIDTH-1:0]   r0_rdata,
    output logic [1:0]              r0_resp,

    input  logic                    r1_req,
    input  logic                    r1_we,
    input  logic [ADDR_WIDTH-1:0]   r1_addr,
    input  logic [DATA_WIDTH-1:0]   r1_wdata,
    input  logic [DATA_WIDTH/8-1:0] r1_wstrb,
    output logic                    r1_done,
    output logic [DATA_WIDTH-1:0]   r1_rdata,
    output logic [1:0]              r1_resp,

    axi_lite_arb_master_if.master   m_axi
);

    state_e state_q, state_d;

    logic [1:0]              gnt;
    logic                    grant_q;
    logic                    cmd_we_q;
    logic [ADDR_WIDTH-1:0]   cmd_addr_q;
    logic [DATA_WIDTH-1:0]   cmd_wdata_q;
    logic [DATA_WIDTH/8-1:0] cmd_wstrb_q;
    logic                    aw_done_q, w_done_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              resp_q;

    logic idle, sel_we, aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign idle   = (state_q == StIdle);
    assign sel_we = gnt[1] ? r1_we : r0_we;
    assign aw_hs  = m_axi.awvalid && m_axi.awready;
    assign w_hs   = m_axi.wvalid && m_axi.wready;
    assign b_hs   = m_axi.bvalid && m_axi.bready;
    assign ar_hs  = m_axi.arvalid && m_axi.arready;
    assign r_hs   = m_axi.rvalid && m_axi.rready;

    rr_arb2 u_arb (
        .clk_i     (S_AXI_ACLK),
        .rst_ni    (S_AXI_ARESETN),
        .req_i     ({r1_req, r0_req}),
        .advance_i (idle),
        .gnt_o     (gnt)
    );

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (gnt != 2'b00) state_d = sel_we ? StWr : StRd;
            StWr:     if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = StWrResp;
            StWrResp: if (b_hs) state_d = StDone;
            StRd:     if (ar_hs) state_d = StRdData;
            StRdData: if (r_hs) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Command payload is registered at grant so the bus sees it stable for the whole transfer.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            grant_q     <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_wstrb_q <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= RESP_OKAY;
        end else begin
            if (idle && (gnt != 2'b00)) begin
                grant_q     <= gnt[1];
                cmd_we_q    <= sel_we;
                cmd_addr_q  <= gnt[1] ? r1_addr  : r0_addr;
                cmd_wdata_q <= gnt[1] ? r1_wdata : r0_wdata;
                cmd_wstrb_q <= gnt[1] ? r1_wstrb : r0_wstrb;
            end
            if (state_q == StWr) begin
                if (aw_hs) aw_done_q <= 1'b1;
                if (w_hs)  w_done_q  <= 1'b1;
            end else begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (b_hs) begin
                rdata_q <= '0;
                resp_q  <= m_axi.bresp;
            end
            if (r_hs) begin
                rdata_q <= m_axi.rdata;
                resp_q  <= m_axi.rresp;
            end
        end
    end

    always_comb begin
        m_axi.awvalid = (state_q == StWr) && !aw_done_q;
        m_axi.wvalid  = (state_q == StWr) && !w_done_q;
        m_axi.bready  = (state_q == StWrResp);
        m_axi.arvalid = (state_q == StRd);
        m_axi.rready  = (state_q == StRdData);
        m_axi.awaddr  = cmd_addr_q;
        m_axi.araddr  = cmd_addr_q;
        m_axi.wdata   = cmd_wdata_q;
        m_axi.wstrb   = cmd_wstrb_q;
        r0_done       = (state_q == StDone) && !grant_q;
        r1_done       = (state_q == StDone) && grant_q;
        r0_rdata      = rdata_q;
        r1_rdata      = rdata_q;
        r0_resp       = resp_q;
        r1_resp       = resp_q;
    end

    logic unused_cmd_we;
    assign unused_cmd_we = cmd_we_q;

endmodule

// File: tb/tb_axi_lite_arb_master.sv
// Directed bench: behavioural AXI4-Lite register slave with tunable ready delays and BRESP.
module tb_axi_lite_arb_master;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  req, we;
    logic [4:0]  addr [2];
    logic [31:0] wdata [2];
    logic [3:0]  wstrb [2];
    logic [1:0]  done;
    logic [31:0] rdata0, rdata1;
    logic [1:0]  resp0, resp1;

    int n_cmp = 0;
    int n_fail = 0;

    axi_lite_arb_master_if bus ();

    axi_lite_arb_master dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .r0_req        (req[0]),
        .r0_we         (we[0]),
        .r0_addr       (addr[0]),
        .r0_wdata      (wdata[0]),
        .r0_wstrb      (wstrb[0]),
        .r0_done       (done[0]),
        .r0_rdata      (rdata0),
        .r0_resp       (resp0),
        .r1_req        (req[1]),
        .r1_we         (we[1]),
        .r1_addr       (addr[1]),
        .r1_wdata      (wdata[1]),
        .r1_wstrb      (wstrb[1]),
        .r1_done       (done[1]),
        .r1_rdata      (rdata1),
        .r1_resp       (resp1),
        .m_axi         (bus)
    );

    // ---------------- slave model ----------------
    logic [31:0] mem [8];
    int          aw_delay = 0, w_delay = 0, aw_wait, w_wait, aw_hs_cnt = 0;
    bit          b_hold = 1'b0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic        aw_got, w_got, s_bvalid, s_rvalid;
    logic [4:0]  aw_addr_l;
    logic [31:0] w_data_l, s_rdata;
    logic [3:0]  w_strb_l;
    logic [1:0]  s_bresp;

    assign bus.awready = bus.awvalid && (aw_wait >= aw_delay);
    assign bus.wready  = bus.wvalid && (w_wait >= w_delay);
    assign bus.arready = bus.arvalid;
    assign bus.bvalid  = s_bvalid;
    assign bus.bresp   = s_bresp;
    assign bus.rvalid  = s_rvalid;
    assign bus.rdata   = s_rdata;
    assign bus.rresp   = 2'b00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_wait  <= 0;
            w_wait   <= 0;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            s_bvalid <= 1'b0;
            s_bresp  <= 2'b00;
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
        end else begin
            aw_wait <= (bus.awvalid && !bus.awready) ? aw_wait + 1 : 0;
            w_wait  <= (bus.wvalid && !bus.wready) ? w_wait + 1 : 0;
            if (bus.awvalid && bus.awready) begin
                aw_got    <= 1'b1;
                aw_addr_l <= bus.awaddr;
                aw_hs_cnt <= aw_hs_cnt + 1;
            end
            if (bus.wvalid && bus.wready) begin
                w_got    <= 1'b1;
                w_data_l <= bus.wdata;
                w_strb_l <= bus.wstrb;
            end
            if (s_bvalid && bus.bready) begin
                s_bvalid <= 1'b0;
            end else if ((aw_got || (bus.awvalid && bus.awready)) &&
                         (w_got || (bus.wvalid && bus.wready)) && !b_hold && !s_bvalid) begin
                for (int b = 0; b < 4; b++) begin
                    if ((w_got ? w_strb_l[b] : bus.wstrb[b]))
                        mem[aw_got ? aw_addr_l[4:2] : bus.awaddr[4:2]][8*b +: 8] <=
                            w_got ? w_data_l[8*b +: 8] : bus.wdata[8*b +: 8];
                end
                s_bvalid <= 1'b1;
                s_bresp  <= bresp_cfg;
                aw_got   <= 1'b0;
                w_got    <= 1'b0;
            end
            if (s_rvalid && bus.rready) s_rvalid <= 1'b0;
            if (bus.arvalid && bus.arready) begin
                s_rvalid <= 1'b1;
                s_rdata  <= mem[bus.araddr[4:2]];
            end
        end
    end

    // ---------------- requester driver ----------------
    task automatic issue(input int idx, input logic w, input logic [4:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd, output logic [1:0] rsp,
                         output int cyc, output logic other, output logic to);
        @(negedge clk);
        we[idx] = w; addr[idx] = a; wdata[idx] = d; wstrb[idx] = s; req[idx] = 1'b1;
        cyc = 0; other = 1'b0; to = 1'b1; rd = '0; rsp = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            cyc++;
            if (done[1-idx]) other = 1'b1;
            if (done[idx]) begin
                rd  = idx ? rdata1 : rdata0;
                rsp = idx ? resp1 : resp0;
                req[idx] = 1'b0;
                to = 1'b0;
                break;
            end
        end
        req[idx] = 1'b0;
    endtask

    logic [31:0] rd;
    logic [1:0]  rsp;
    int          cyc;
    logic        other, to;

    task automatic test_reset;
        logic [6:0] ctl;
        repeat (2) @(negedge clk);
        ctl = {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, done};
        n_cmp++;
        if (ctl !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, 7'b0);
        end
        n_cmp++;
        if ({bus.awaddr, bus.araddr, bus.wdata, bus.wstrb, rdata0, resp0} !== '0) begin
            n_fail++; $display("FAIL reset_payload: got %h want 0",
                               {bus.awaddr, bus.araddr, bus.wdata, bus.wstrb, rdata0, resp0});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_write;
        int hs0;
        hs0 = aw_hs_cnt;
        issue(0, 1'b1, 5'h04, 32'hCAFE1234, 4'hF, rd, rsp, cyc, other, to);
        n_cmp++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL write_timeout: got %b want 0", to); end
        n_cmp++;
        // req cycle through done cycle inclusive is 4 cycles: done at 3rd sample after req
        if (cyc != 3) begin n_fail++; $display("FAIL write_latency: got %0d want 3", cyc); end
        n_cmp++;
        if (rsp !== 2'b00) begin n_fail++; $display("FAIL write_resp: got %b want 00", rsp); end
        n_cmp++;
        if (aw_hs_cnt - hs0 != 1) begin
            n_fail++; $display("FAIL write_aw_count: got %0d want 1", aw_hs_cnt - hs0);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 2'b00) begin n_fail++; $display("FAIL write_done_pulse: got %b want 00", done); end
    endtask

    task automatic test_read;
        issue(1, 1'b0, 5'h04, 32'h0, 4'h0, rd, rsp, cyc, other, to);
        n_cmp++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL read_timeout: got %b want 0", to); end
        n_cmp++;
        if (rd !== 32'hCAFE1234) begin n_fail++; $display("FAIL read_data: got %h want cafe1234", rd); end
        n_cmp++;
        if (rsp !== 2'b00) begin n_fail++; $display("FAIL read_resp: got %b want 00", rsp); end
        n_cmp++;
        if (other !== 1'b0) begin n_fail++; $display("FAIL read_r0_done: got %b want 0", other); end
        n_cmp++;
        if (cyc != 3) begin n_fail++; $display("FAIL read_latency: got %0d want 3", cyc); end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  ord;
        int          n;
        logic        overlap;
        logic [31:0] got0, got1;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            we[0] = (r == 0); addr[0] = (r == 0) ? 5'h08 : 5'h0C;
            wdata[0] = 32'h12345678; wstrb[0] = 4'hF;
            we[1] = (r == 0); addr[1] = (r == 0) ? 5'h0C : 5'h08;
            wdata[1] = 32'h9ABCDEF0; wstrb[1] = 4'hF;
            req = 2'b11;
            n = (r == 0) ? 0 : 2; overlap = 1'b0;
            for (int i = 0; i < 40 && req != 2'b00; i++) begin
                @(negedge clk);
                if (done == 2'b11) overlap = 1'b1;
                for (int k = 0; k < 2; k++) begin
                    if (done[k]) begin
                        if (n < 4) ord[n] = k[0];
                        n++;
                        if (k == 0) got0 = rdata0; else got1 = rdata1;
                        req[k] = 1'b0;
                    end
                end
            end
            req = 2'b00;
            n_cmp++;
            if (overlap !== 1'b0) begin n_fail++; $display("FAIL b2b_overlap: got 1 want 0"); end
        end
        n_cmp++;
        if (n != 4 || ord !== 4'b1010) begin
            n_fail++; $display("FAIL b2b_order: got n=%0d ord=%b want n=4 ord=1010", n, ord);
        end
        n_cmp++;
        if (got0 !== 32'h9ABCDEF0) begin n_fail++; $display("FAIL b2b_r0_rdata: got %h want 9abcdef0", got0); end
        n_cmp++;
        if (got1 !== 32'h12345678) begin n_fail++; $display("FAIL b2b_r1_rdata: got %h want 12345678", got1); end
    endtask

    task automatic test_independent_valid;
        logic [4:0] awv, wv;
        int         dcyc;
        logic [4:0] a_seen;
        for (int t = 0; t < 2; t++) begin
            aw_delay = (t == 0) ? 0 : 3;
            w_delay  = (t == 0) ? 3 : 0;
            @(negedge clk);
            we[0] = 1'b1; addr[0] = (t == 0) ? 5'h10 : 5'h14;
            wdata[0] = (t == 0) ? 32'h11112222 : 32'hA5A55A5A; wstrb[0] = 4'hF;
            req[0] = 1'b1;
            awv = '0; wv = '0; dcyc = 0; a_seen = '0;
            for (int c = 1; c <= 12 && dcyc == 0; c++) begin
                @(negedge clk);
                if (c <= 5) begin awv[c-1] = bus.awvalid; wv[c-1] = bus.wvalid; end
                if (c == 4) a_seen = bus.awaddr;
                if (done[0]) begin dcyc = c; req[0] = 1'b0; end
            end
            req[0] = 1'b0;
            n_cmp++;
            if (awv !== ((t == 0) ? 5'b00001 : 5'b01111)) begin
                n_fail++; $display("FAIL indep_awvalid_%0d: got %b", t, awv);
            end
            n_cmp++;
            if (wv !== ((t == 0) ? 5'b01111 : 5'b00001)) begin
                n_fail++; $display("FAIL indep_wvalid_%0d: got %b", t, wv);
            end
            n_cmp++;
            if (dcyc != 6) begin n_fail++; $display("FAIL indep_done_cycle_%0d: got %0d want 6", t, dcyc); end
            n_cmp++;
            if (a_seen !== ((t == 0) ? 5'h10 : 5'h14)) begin
                n_fail++; $display("FAIL indep_awaddr_%0d: got %h", t, a_seen);
            end
        end
        aw_delay = 0; w_delay = 0;
        issue(1, 1'b0, 5'h10, 32'h0, 4'h0, rd, rsp, cyc, other, to);
        n_cmp++;
        if (rd !== 32'h11112222) begin n_fail++; $display("FAIL indep_data_10: got %h want 11112222", rd); end
        issue(1, 1'b0, 5'h14, 32'h0, 4'h0, rd, rsp, cyc, other, to);
        n_cmp++;
        if (rd !== 32'hA5A55A5A) begin n_fail++; $display("FAIL indep_data_14: got %h want a5a55a5a", rd); end
    endtask

    task automatic test_slverr;
        logic [5:0] ctl;
        bresp_cfg = 2'b10;
        issue(0, 1'b1, 5'h18, 32'h55AA55AA, 4'hF, rd, rsp, cyc, other, to);
        bresp_cfg = 2'b00;
        n_cmp++;
        if (to !== 1'b0 || rsp !== 2'b10) begin
            n_fail++; $display("FAIL slverr_resp: got to=%b resp=%b want to=0 resp=10", to, rsp);
        end
        @(negedge clk);
        ctl = {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, done[0]};
        n_cmp++;
        if (ctl !== 6'b0) begin n_fail++; $display("FAIL slverr_idle: got %b want 000000", ctl); end
    endtask

    task automatic test_reset_midflight;
        logic       seen;
        logic [6:0] ctl;
        b_hold = 1'b1;
        @(negedge clk);
        we[0] = 1'b1; addr[0] = 5'h1C; wdata[0] = 32'hDEADBEEF; wstrb[0] = 4'hF; req[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.bready) begin seen = 1'b1; break; end
        end
        n_cmp++;
        if (seen !== 1'b1) begin n_fail++; $display("FAIL midrst_wr_resp: got 0 want 1"); end
        #2 rst_n = 1'b0;
        req[0] = 1'b0;
        #1;
        ctl = {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, done};
        n_cmp++;
        if (ctl !== 7'b0) begin n_fail++; $display("FAIL midrst_ctl: got %b want 0000000", ctl); end
        n_cmp++;
        if (bus.awaddr !== 5'h0) begin n_fail++; $display("FAIL midrst_awaddr: got %h want 00", bus.awaddr); end
        b_hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(1, 1'b1, 5'h1C, 32'h0BADF00D, 4'hF, rd, rsp, cyc, other, to);
        n_cmp++;
        if (to !== 1'b0 || rsp !== 2'b00 || cyc != 3) begin
            n_fail++; $display("FAIL midrst_fresh_write: got to=%b resp=%b cyc=%0d want 0/00/3", to, rsp, cyc);
        end
        issue(0, 1'b0, 5'h1C, 32'h0, 4'h0, rd, rsp, cyc, other, to);
        n_cmp++;
        if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL midrst_readback: got %h want 0badf00d", rd); end
    endtask

    initial begin
        req = 2'b00; we = 2'b00;
        for (int k = 0; k < 2; k++) begin addr[k] = '0; wdata[k] = '0; wstrb[k] = '0; end
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_independent_valid();
        test_slverr();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
